// File: rtl/opl3_timer_block.sv
// rtl/opl3_timer_block.sv - OPL3 Timer 1/Timer 2 block: register decode, prescalers, counters, flags, status/IRQ
module opl3_timer_block #(
    parameter int TIMER1_TICK_CYCLES = 1966,
    parameter int TIMER2_TICK_CYCLES = 7864
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [17:0] opl3_reg_wr,
    output logic [7:0]  status,
    output logic        irq_n
);
    localparam int W1 = (TIMER1_TICK_CYCLES > 1) ? $clog2(TIMER1_TICK_CYCLES) : 1;
    localparam int W2 = (TIMER2_TICK_CYCLES > 1) ? $clog2(TIMER2_TICK_CYCLES) : 1;
    localparam logic [W1-1:0] LAST1 = W1'(TIMER1_TICK_CYCLES - 1);
    localparam logic [W2-1:0] LAST2 = W2'(TIMER2_TICK_CYCLES - 1);

    logic        wr_valid;
    logic        wr_bank;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        clr_flags;

    logic [W1-1:0] pre1;
    logic [W2-1:0] pre2;
    logic [1:0]    tick;

    logic [7:0] preset      [2];
    logic [7:0] preset_next [2];
    logic [7:0] cnt         [2];
    logic [7:0] cnt_next    [2];
    logic [1:0] st, st_next;
    logic [1:0] mt, mt_next;
    logic [1:0] ft, ft_next;
    logic [1:0] ovf;

    assign wr_valid = opl3_reg_wr[17];
    assign wr_bank  = opl3_reg_wr[16];
    assign wr_addr  = opl3_reg_wr[15:8];
    assign wr_data  = opl3_reg_wr[7:0];
    assign wr_en    = wr_valid && !wr_bank;

    // Prescalers run from reset regardless of the start bits
    always_ff @(posedge clk) begin
        if (reset) begin
            pre1 <= '0;
            pre2 <= '0;
        end else begin
            pre1 <= (pre1 == LAST1) ? '0 : pre1 + W1'(1);
            pre2 <= (pre2 == LAST2) ? '0 : pre2 + W2'(1);
        end
    end

    assign tick[0] = (pre1 == LAST1);
    assign tick[1] = (pre2 == LAST2);

    always_comb begin
        preset_next = preset;
        st_next     = st;
        mt_next     = mt;
        clr_flags   = 1'b0;
        if (wr_en) begin
            if (wr_addr == 8'h02) preset_next[0] = wr_data;
            if (wr_addr == 8'h03) preset_next[1] = wr_data;
            if (wr_addr == 8'h04) begin
                if (wr_data[7]) begin
                    clr_flags = 1'b1;
                end else begin
                    mt_next = {wr_data[5], wr_data[6]};
                    st_next = wr_data[1:0];
                end
            end
        end
        // Overflow reload uses the preset as committed this cycle
        for (int i = 0; i < 2; i++) begin
            cnt_next[i] = cnt[i];
            ovf[i]      = 1'b0;
            if (st_next[i] && !st[i]) begin
                cnt_next[i] = preset_next[i];
            end else if (st[i] && tick[i]) begin
                if (cnt[i] == 8'hFF) begin
                    ovf[i]      = 1'b1;
                    cnt_next[i] = preset_next[i];
                end else begin
                    cnt_next[i] = cnt[i] + 8'd1;
                end
            end
            // Set beats a same-cycle clear so no overflow is lost
            ft_next[i] = (ft[i] && !clr_flags) || (ovf[i] && !mt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            preset <= '{default: 8'h00};
            cnt    <= '{default: 8'h00};
            st     <= 2'b00;
            mt     <= 2'b00;
            ft     <= 2'b00;
        end else begin
            preset <= preset_next;
            cnt    <= cnt_next;
            st     <= st_next;
            mt     <= mt_next;
            ft     <= ft_next;
        end
    end

    assign status = {ft[0] | ft[1], ft[0], ft[1], 5'b00000};
    assign irq_n  = ~(ft[0] | ft[1]);
endmodule

// File: tb/tb_opl3_timer_block.sv
// tb/tb_opl3_timer_block.sv - randomized and directed checks of opl3_timer_block against a cycle model
module tb_opl3_timer_block;
    localparam int P1 = 4;
    localparam int P2 = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [17:0] opl3_reg_wr = '0;
    logic [7:0]  status;
    logic        irq_n;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_cyc;
    int m_preset [2];
    int m_cnt    [2];
    bit m_st     [2];
    bit m_mt     [2];
    bit m_ft     [2];

    opl3_timer_block #(
        .TIMER1_TICK_CYCLES(P1),
        .TIMER2_TICK_CYCLES(P2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .opl3_reg_wr(opl3_reg_wr),
        .status     (status),
        .irq_n      (irq_n)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] wr(input bit v, input bit b, input logic [7:0] a, input logic [7:0] d);
        return {v, b, a, d};
    endfunction

    function automatic logic [7:0] exp_status();
        logic [7:0] s;
        s = 8'h00;
        s[7] = m_ft[0] | m_ft[1];
        s[6] = m_ft[0];
        s[5] = m_ft[1];
        return s;
    endfunction

    task automatic model_step(input bit rst, input logic [17:0] w);
        bit we, tk [2], st_old [2], mt_old [2], ovf;
        int a, d;
        if (rst) begin
            m_cyc = 0;
            for (int i = 0; i < 2; i++) begin
                m_preset[i] = 0; m_cnt[i] = 0; m_st[i] = 0; m_mt[i] = 0; m_ft[i] = 0;
            end
            return;
        end
        we = w[17] && !w[16];
        a  = int'(w[15:8]);
        d  = int'(w[7:0]);
        tk[0] = (m_cyc % P1) == P1 - 1;
        tk[1] = (m_cyc % P2) == P2 - 1;
        if (we && a == 2) m_preset[0] = d;
        if (we && a == 3) m_preset[1] = d;
        for (int i = 0; i < 2; i++) begin
            st_old[i] = m_st[i];
            mt_old[i] = m_mt[i];
        end
        for (int i = 0; i < 2; i++) begin
            ovf = 0;
            if (we && a == 4 && d < 128 && ((d >> i) & 1) == 1 && !st_old[i]) begin
                m_cnt[i] = m_preset[i];
            end else if (st_old[i] && tk[i]) begin
                if (m_cnt[i] == 255) begin
                    ovf = 1;
                    m_cnt[i] = m_preset[i];
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
            if (we && a == 4 && d >= 128) m_ft[i] = 0;
            if (ovf && !mt_old[i]) m_ft[i] = 1;
        end
        if (we && a == 4 && d < 128) begin
            m_st[0] = d[0];
            m_st[1] = d[1];
            m_mt[0] = d[6];
            m_mt[1] = d[5];
        end
        m_cyc++;
    endtask

    task automatic cyc(input bit rst, input logic [17:0] w);
        reset = rst;
        opl3_reg_wr = w;
        @(posedge clk);
        model_step(rst, w);
        #1;
        reset = 1'b0;
        opl3_reg_wr = '0;
    endtask

    task automatic test_reset();
        cyc(1'b1, '0);
        for (int i = 0; i < 100; i++) begin
            cyc(1'b0, '0);
            checks++;
            if (status !== 8'h00 || irq_n !== 1'b1) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: status=%h irq_n=%b required status=00 irq_n=1", i, status, irq_n);
            end
        end
    endtask

    task automatic test_t1_overflow();
        cyc(1'b0, wr(1, 0, 8'h02, 8'hFE));
        cyc(1'b0, wr(1, 0, 8'h04, 8'h01));
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, '0);
            checks++;
            if (status !== exp_status() || irq_n !== ~exp_status()[7]) begin
                errors++;
                $display("FAIL t1_overflow cycle %0d: status=%h irq_n=%b required status=%h", i, status, irq_n, exp_status());
            end
        end
        checks++;
        if (status !== 8'hC0 || irq_n !== 1'b0) begin
            errors++;
            $display("FAIL t1_overflow_final: status=%h irq_n=%b required status=c0 irq_n=0", status, irq_n);
        end
    endtask

    task automatic test_irq_clear();
        cyc(1'b0, wr(1, 0, 8'h04, 8'h80));
        checks++;
        if (status !== 8'h00 || irq_n !== 1'b1) begin
            errors++;
            $display("FAIL irq_clear: status=%h irq_n=%b required status=00 irq_n=1", status, irq_n);
        end
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, '0);
            checks++;
            if (status !== exp_status()) begin
                errors++;
                $display("FAIL irq_clear_rerun cycle %0d: status=%h required %h", i, status, exp_status());
            end
        end
        checks++;
        if (status !== 8'hC0) begin
            errors++;
            $display("FAIL irq_clear_reset_again: status=%h required c0", status);
        end
    endtask

    task automatic test_mask();
        cyc(1'b0, wr(1, 0, 8'h04, 8'h80));
        cyc(1'b0, wr(1, 0, 8'h04, 8'h00));
        cyc(1'b0, wr(1, 0, 8'h03, 8'hFF));
        cyc(1'b0, wr(1, 0, 8'h04, 8'h22));
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, '0);
            checks++;
            if (status !== 8'h00 || irq_n !== 1'b1) begin
                errors++;
                $display("FAIL mask_t2 cycle %0d: status=%h irq_n=%b required status=00 irq_n=1", i, status, irq_n);
            end
        end
        cyc(1'b0, wr(1, 0, 8'h04, 8'h02));
        for (int i = 0; i < 18; i++) begin
            cyc(1'b0, '0);
            checks++;
            if (status !== exp_status()) begin
                errors++;
                $display("FAIL unmask_t2 cycle %0d: status=%h required %h", i, status, exp_status());
            end
        end
        checks++;
        if (status !== 8'hA0 || irq_n !== 1'b0) begin
            errors++;
            $display("FAIL unmask_t2_final: status=%h irq_n=%b required status=a0 irq_n=0", status, irq_n);
        end
    endtask

    task automatic test_same_cycle();
        int guard;
        cyc(1'b0, wr(1, 0, 8'h04, 8'h00));
        cyc(1'b0, wr(1, 0, 8'h04, 8'h80));
        cyc(1'b0, wr(1, 0, 8'h02, 8'hFF));
        cyc(1'b0, wr(1, 0, 8'h04, 8'h01));
        guard = 0;
        while ((m_cyc % P1) != P1 - 1 && guard < 2 * P1) begin
            cyc(1'b0, '0);
            guard++;
        end
        checks++;
        if ((m_cyc % P1) != P1 - 1) begin
            errors++;
            $display("FAIL same_cycle_align: could not reach a tick1 cycle");
        end
        cyc(1'b0, wr(1, 0, 8'h04, 8'h80));
        checks++;
        if (status !== 8'hC0 || irq_n !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_set_wins: status=%h irq_n=%b required status=c0 irq_n=0", status, irq_n);
        end
    endtask

    task automatic test_ignored_and_reset();
        cyc(1'b0, wr(1, 1, 8'h04, 8'h80));
        cyc(1'b0, wr(1, 1, 8'h02, 8'h00));
        cyc(1'b0, wr(0, 0, 8'h04, 8'h80));
        checks++;
        if (status !== 8'hC0) begin
            errors++;
            $display("FAIL ignored_writes: status=%h required c0", status);
        end
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, wr(0, 0, 8'h04, 8'h00));
            checks++;
            if (status !== exp_status()) begin
                errors++;
                $display("FAIL ignored_follow cycle %0d: status=%h required %h", i, status, exp_status());
            end
        end
        cyc(1'b0, wr(1, 0, 8'h04, 8'h23));
        cyc(1'b0, '0);
        cyc(1'b1, '0);
        checks++;
        if (status !== 8'h00 || irq_n !== 1'b1) begin
            errors++;
            $display("FAIL midcount_reset: status=%h irq_n=%b required status=00 irq_n=1", status, irq_n);
        end
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, '0);
            checks++;
            if (status !== 8'h00 || irq_n !== 1'b1) begin
                errors++;
                $display("FAIL after_reset cycle %0d: status=%h irq_n=%b required status=00 irq_n=1", i, status, irq_n);
            end
        end
    endtask

    task automatic test_random();
        logic [17:0] w;
        int r;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 19);
            w = 18'($urandom);
            if (r < 12) begin
                w[17] = 1'b0;
            end else if (r < 14) begin
                w = wr(1, 0, ($urandom_range(0, 1) != 0) ? 8'h02 : 8'h03, 8'($urandom_range(240, 255)));
            end else if (r < 17) begin
                w = wr(1, 0, 8'h04, {1'b0, 7'($urandom)});
            end else if (r < 18) begin
                w = wr(1, 0, 8'h04, {1'b1, 7'($urandom)});
            end else if (r < 19) begin
                w[17] = 1'b1;
                w[16] = 1'b1;
            end else begin
                w = wr(1, 0, 8'($urandom_range(0, 7)), 8'($urandom));
            end
            cyc(1'b0, w);
            checks++;
            if (status !== exp_status() || irq_n !== ~exp_status()[7]) begin
                errors++;
                $display("FAIL random cycle %0d: status=%h irq_n=%b required status=%h", i, status, irq_n, exp_status());
            end
        end
    endtask

    initial begin
        model_step(1'b1, '0);
        test_reset();
        test_t1_overflow();
        test_irq_clear();
        test_mask();
        test_same_cycle();
        test_ignored_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
